// File: rtl/parity_frame_accum.sv
// Purpose : XOR-accumulates FRAME_LEN words of WIDTH bits and emits one frame parity bit (generate) or error flag (check).
// Latency : result valid the cycle after the last beat of a frame is accepted.
// Backpr. : result held stable while out_ready=0; in_ready stays low until the result is taken.
//
// Ports   : clk/rst_n (async active-low), mode (0 gen / 1 check, latched on first beat),
//           in_valid/in_ready/in_data/in_par (word stream, in_par sampled on the last beat only),
//           out_valid/out_ready/out_par/out_err (frame result), err_cnt (optional).
// Option  : define PARITY_ERR_CNT_EN to add the saturating 8-bit err_cnt output.
module parity_frame_accum #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   parameter int ODD       = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_par,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_par,
   output logic             out_err
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   localparam int            CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
   localparam logic          ODD_BIT  = (ODD != 0);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t        state;
   logic          acc;
   logic [CW-1:0] cnt;
   logic          mode_q;

   logic          beat;
   logic          word_par;
   logic          frame_par;
   logic          mode_eff;
   logic          last_beat;

   // Handshake outputs are pure decodes of the registered state, so there is
   // never a combinational path from in_valid/out_ready to in_ready/out_valid.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);

   assign beat      = in_valid & in_ready;
   assign word_par  = ^in_data;
   assign frame_par = acc ^ word_par ^ ODD_BIT;
   assign last_beat = (cnt == CNT_LAST);

   // With single-word frames the first beat is also the last, so mode_q has
   // not been written yet when the result is formed; use the live mode input.
   assign mode_eff  = (FRAME_LEN == 1) ? mode : mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ACCUM;
         acc     <= 1'b0;
         cnt     <= '0;
         mode_q  <= 1'b0;
         out_par <= 1'b0;
         out_err <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (beat) begin
                  if (cnt == '0) begin
                     mode_q <= mode;
                  end
                  acc <= acc ^ word_par;
                  if (last_beat) begin
                     out_par <= frame_par;
                     out_err <= mode_eff & (frame_par != in_par);
                     cnt     <= '0;
                     state   <= HOLD;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc   <= 1'b0;
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

`ifdef PARITY_ERR_CNT_EN
   // Counts delivered error results; sticks at 255 rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'd0;
      end else if (out_valid && out_ready && out_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_parity_frame_accum.sv
module tb_parity_frame_accum;

   logic       clk;
   logic       rst_n;
   logic       mode;
   logic       in_valid;
   logic       in_valid1;
   logic [7:0] in_data;
   logic       in_par;
   logic       out_ready;

   logic in_ready,   out_valid,   out_par,   out_err;
   logic o_in_ready, o_out_valid, o_out_par, o_out_err;
   logic s_in_ready, s_out_valid, s_out_par, s_out_err;
`ifdef PARITY_ERR_CNT_EN
   logic [7:0] err_cnt, o_err_cnt, s_err_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Even parity, frame of 4.
   parity_frame_accum #(.WIDTH(8), .FRAME_LEN(4), .ODD(0)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_par(in_par), .out_valid(out_valid), .out_ready(out_ready),
      .out_par(out_par), .out_err(out_err)
`ifdef PARITY_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   // Odd parity twin fed the same stream.
   parity_frame_accum #(.WIDTH(8), .FRAME_LEN(4), .ODD(1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(o_in_ready),
      .in_data(in_data), .in_par(in_par), .out_valid(o_out_valid), .out_ready(out_ready),
      .out_par(o_out_par), .out_err(o_out_err)
`ifdef PARITY_ERR_CNT_EN
      , .err_cnt(o_err_cnt)
`endif
   );

   // Single-word frames, own valid so it only sees its dedicated test.
   parity_frame_accum #(.WIDTH(8), .FRAME_LEN(1), .ODD(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid1), .in_ready(s_in_ready),
      .in_data(in_data), .in_par(in_par), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_par(s_out_par), .out_err(s_out_err)
`ifdef PARITY_ERR_CNT_EN
      , .err_cnt(s_err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Four back-to-back beats; m[i] is the mode on beat i. in_par carries the
   // wanted value only on the last beat and its complement before that.
   task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] d3, input logic [3:0] m, input logic p);
      logic [7:0] w [4];
      w = '{d0, d1, d2, d3};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = w[i];
         mode     = m[i];
         in_par   = (i == 3) ? p : ~p;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
      in_data = 8'h00; in_par = 1'b0; out_ready = 1'b1;
      #3;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_par !== 1'b0) begin n_err++; $display("FAIL rst_out_par: got %b want 0", out_par); end
      n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL rst_out_err: got %b want 0", out_err); end
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_in_ready: got %b want 1", s_in_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_generate;
      send_frame(8'h01, 8'h03, 8'h07, 8'h00, 4'b0000, 1'b0);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gen_out_valid: got %b want 1", out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL gen_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_par !== 1'b0) begin n_err++; $display("FAIL gen_out_par: got %b want 0", out_par); end
      n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL gen_out_err: got %b want 0", out_err); end
      n_cmp++; if (o_out_par !== 1'b1) begin n_err++; $display("FAIL gen_odd_par: got %b want 1", o_out_par); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gen_out_valid_drop: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL gen_in_ready_back: got %b want 1", in_ready); end
   endtask

   task automatic test_odd_par;
      send_frame(8'h01, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
      @(negedge clk);
      n_cmp++; if (out_par !== 1'b1) begin n_err++; $display("FAIL odd_even_par: got %b want 1", out_par); end
      n_cmp++; if (o_out_par !== 1'b0) begin n_err++; $display("FAIL odd_odd_par: got %b want 0", o_out_par); end
      n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL odd_out_err: got %b want 0", out_err); end
      @(posedge clk); #1;
   endtask

   task automatic test_check;
      send_frame(8'h01, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b1);
      @(negedge clk);
      n_cmp++; if (out_par !== 1'b1) begin n_err++; $display("FAIL chk1_par: got %b want 1", out_par); end
      n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL chk1_err: got %b want 0", out_err); end
      n_cmp++; if (o_out_err !== 1'b1) begin n_err++; $display("FAIL chk1_odd_err: got %b want 1", o_out_err); end
      @(posedge clk); #1;
      send_frame(8'h01, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b0);
      @(negedge clk);
      n_cmp++; if (out_par !== 1'b1) begin n_err++; $display("FAIL chk0_par: got %b want 1", out_par); end
      n_cmp++; if (out_err !== 1'b1) begin n_err++; $display("FAIL chk0_err: got %b want 1", out_err); end
      n_cmp++; if (o_out_err !== 1'b0) begin n_err++; $display("FAIL chk0_odd_err: got %b want 0", o_out_err); end
      @(posedge clk); #1;
   endtask

   task automatic test_mode_latch;
      // check on first beat, generate afterwards: frame stays in check mode
      send_frame(8'h01, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0);
      @(negedge clk);
      n_cmp++; if (out_err !== 1'b1) begin n_err++; $display("FAIL latch_chk_err: got %b want 1", out_err); end
      @(posedge clk); #1;
      // generate on first beat, check afterwards: no error reported
      send_frame(8'h01, 8'h00, 8'h00, 8'h00, 4'b1110, 1'b0);
      @(negedge clk);
      n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL latch_gen_err: got %b want 0", out_err); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      send_frame(8'h03, 8'h01, 8'h00, 8'h00, 4'b0000, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
         n_cmp++; if (out_par !== 1'b1) begin n_err++; $display("FAIL bp_par[%0d]: got %b want 1", k, out_par); end
         n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL bp_err[%0d]: got %b want 0", k, out_err); end
         // offered words while held must be ignored
         in_valid = 1'b1;
         in_data  = 8'h07;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      send_frame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_par !== 1'b0) begin n_err++; $display("FAIL bp_next_par: got %b want 0", out_par); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      // reset while a result is held
      out_ready = 1'b0;
      send_frame(8'h01, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
      @(negedge clk);
      n_cmp++; if (out_par !== 1'b1) begin n_err++; $display("FAIL rhold_pre_par: got %b want 1", out_par); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rhold_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rhold_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_par !== 1'b0) begin n_err++; $display("FAIL rhold_par: got %b want 0", out_par); end
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      // reset after two beats of a frame
      in_valid = 1'b1; in_data = 8'hFF; mode = 1'b0;
      @(posedge clk); #1;
      in_data = 8'h01;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
      @(negedge clk); rst_n = 1'b1;
      send_frame(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_next_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_par !== 1'b0) begin n_err++; $display("FAIL rmid_next_par: got %b want 0", out_par); end
      @(posedge clk); #1;
   endtask

   task automatic test_frame_len1;
      // mode taken from the current beat: check mode, parity 0 vs expected 1
      in_data = 8'h03; mode = 1'b1; in_par = 1'b1; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      @(negedge clk);
      n_cmp++; if (s_out_valid !== 1'b1) begin n_err++; $display("FAIL f1_valid: got %b want 1", s_out_valid); end
      n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL f1_in_ready: got %b want 0", s_in_ready); end
      n_cmp++; if (s_out_par !== 1'b0) begin n_err++; $display("FAIL f1_par: got %b want 0", s_out_par); end
      n_cmp++; if (s_out_err !== 1'b1) begin n_err++; $display("FAIL f1_err: got %b want 1", s_out_err); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL f1_valid_drop: got %b want 0", s_out_valid); end
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL f1_ready_back: got %b want 1", s_in_ready); end
      in_data = 8'h01; mode = 1'b0; in_par = 1'b0; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      @(negedge clk);
      n_cmp++; if (s_out_par !== 1'b1) begin n_err++; $display("FAIL f1_gen_par: got %b want 1", s_out_par); end
      n_cmp++; if (s_out_err !== 1'b0) begin n_err++; $display("FAIL f1_gen_err: got %b want 0", s_out_err); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL f1_main_idle: got %b want 0", out_valid); end
      @(posedge clk); #1;
   endtask

`ifdef PARITY_ERR_CNT_EN
   task automatic test_err_cnt;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL ec_reset: got %0d want 0", err_cnt); end
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         send_frame(8'h01, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b0);
         @(posedge clk); #1;
      end
      n_cmp++; if (err_cnt !== 8'd3) begin n_err++; $display("FAIL ec_three: got %0d want 3", err_cnt); end
      n_cmp++; if (o_err_cnt !== 8'd0) begin n_err++; $display("FAIL ec_odd_zero: got %0d want 0", o_err_cnt); end
      for (int f = 0; f < 257; f++) begin
         send_frame(8'h01, 8'h00, 8'h00, 8'h00, 4'b1111, 1'b0);
         @(posedge clk); #1;
      end
      n_cmp++; if (err_cnt !== 8'd255) begin n_err++; $display("FAIL ec_saturate: got %0d want 255", err_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_generate();
      test_odd_par();
      test_check();
      test_mode_latch();
      test_backpressure();
      test_reset_mid();
      test_frame_len1();
`ifdef PARITY_ERR_CNT_EN
      test_err_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
